multiboot_arbiter: RTL and testbench

Shares the Spartan-6 ICAP multiboot reconfiguration path between several requesters, such as the menu core selector, a hotkey decoder and a watchdog. Each requester signals a reboot with a rising edge and supplies a 24-bit SPI bitstream address. The block queues the requests, grants one at a time by fixed priority, and holds `spi_addr` stable before pulsing `MBT_REBOOT`. It then holds off further grants while the downstream ICAP command sequence runs. It sits between the requesters and `multiboot_spartan6`, replacing the local reboot-pulse shaper.

---
 rtl/multiboot_arbiter.sv | 146 ++++++++++++++
 tb/tb_multiboot_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multiboot_arbiter.sv
//------------------------------------------------------------------------------
// Module      : multiboot_arbiter
// Description : Fixed-priority arbiter for the Spartan-6 ICAP multiboot path.
//               Queues edge-triggered reboot requests, loads spi_addr, waits
//               SETTLE cycles, pulses MBT_REBOOT, then holds off for HOLDOFF.
//               Optional MBT_LOCK_EN adds a lock input that inhibits grants.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multiboot_arbiter #(
    parameter int          NREQ         = 4,
    parameter logic [23:0] DEFAULT_ADDR = 24'h058000,
    parameter int          SETTLE       = 4,
    parameter int          HOLDOFF      = 32
) (
    input  logic                CLK,
    input  logic                MBT_RESET,
    input  logic [NREQ-1:0]     req,
    input  logic [24*NREQ-1:0]  req_addr,
`ifdef MBT_LOCK_EN
    input  logic                lock,
`endif
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                MBT_REBOOT,
    output logic [23:0]         spi_addr
);

    localparam int C_CNT_MAX = (SETTLE > HOLDOFF) ? SETTLE : HOLDOFF;
    localparam int C_CW      = $clog2(C_CNT_MAX);
    localparam int C_SW      = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_FIRE   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            r_state;
    logic [C_CW-1:0]   r_cnt;
    logic [NREQ-1:0]   r_req_q;
    logic [NREQ-1:0]   r_pending;

    logic [NREQ-1:0]   w_edge;
    logic [C_SW-1:0]   w_sel;
    logic [NREQ-1:0]   w_onehot;
    logic [NREQ-1:0]   w_clr;
    logic [23:0]       w_addr;
    logic              w_permit;
    logic              w_take;

`ifdef MBT_LOCK_EN
    assign w_permit = ~lock;
`else
    assign w_permit = 1'b1;
`endif

    assign w_edge = req & ~r_req_q;

    // Lowest pending index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_sel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = C_SW'(i);
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
    end

    always_comb begin
        w_addr = req_addr[23:0];
        for (int i = 0; i < NREQ; i++) begin
            if (C_SW'(i) == w_sel) begin
                w_addr = req_addr[24*i +: 24];
            end
        end
    end

    assign w_take = (r_state == ST_IDLE) && (|r_pending) && w_permit;
    assign w_clr  = w_take ? w_onehot : '0;

    always_ff @(posedge CLK) begin
        if (MBT_RESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_req_q    <= '0;
            r_pending  <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            MBT_REBOOT <= 1'b0;
            spi_addr   <= DEFAULT_ADDR;
        end else begin
            r_req_q    <= req;
            // A new edge on the bit being granted re-queues it.
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            grant      <= '0;
            MBT_REBOOT <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state  <= ST_SETTLE;
                        spi_addr <= w_addr;
                        grant    <= w_onehot;
                        busy     <= 1'b1;
                        r_cnt    <= C_CW'(SETTLE - 1);
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_FIRE;
                        MBT_REBOOT <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - C_CW'(1);
                    end
                end
                ST_FIRE: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= C_CW'(HOLDOFF - 1);
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - C_CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiboot_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_multiboot_arbiter
// Description : Directed self-checking bench for multiboot_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multiboot_arbiter;

    localparam int          NREQ  = 4;
    localparam logic [23:0] ADDR0 = 24'h100000;
    localparam logic [23:0] ADDR1 = 24'h0B0000;
    localparam logic [23:0] ADDR2 = 24'h200000;
    localparam logic [23:0] ADDR3 = 24'h300000;

    logic              CLK = 1'b0;
    logic              MBT_RESET;
    logic [NREQ-1:0]   req;
    logic [24*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              MBT_REBOOT;
    logic [23:0]       spi_addr;
`ifdef MBT_LOCK_EN
    logic              lock;
`endif

    int checks = 0;
    int errors = 0;
    int n_grant = 0;
    int n_reboot = 0;

    always #5 CLK = ~CLK;

    multiboot_arbiter #(
        .NREQ         (NREQ),
        .DEFAULT_ADDR (24'h058000),
        .SETTLE       (4),
        .HOLDOFF      (32)
    ) u_dut (
        .CLK        (CLK),
        .MBT_RESET  (MBT_RESET),
        .req        (req),
        .req_addr   (req_addr),
`ifdef MBT_LOCK_EN
        .lock       (lock),
`endif
        .grant      (grant),
        .busy       (busy),
        .MBT_REBOOT (MBT_REBOOT),
        .spi_addr   (spi_addr)
    );

    always @(negedge CLK) begin
        if (!MBT_RESET) begin
            if (|grant)     n_grant++;
            if (MBT_REBOOT) n_reboot++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        MBT_RESET = 1'b1;
        req       = '0;
        req_addr  = {ADDR3, ADDR2, ADDR1, ADDR0};
`ifdef MBT_LOCK_EN
        lock      = 1'b0;
`endif
        tick(3);
        check("rst_grant",  32'(grant),      32'h0);
        check("rst_busy",   32'(busy),       32'h0);
        check("rst_reboot", 32'(MBT_REBOOT), 32'h0);
        check("rst_addr",   32'(spi_addr),   32'h058000);
        MBT_RESET = 1'b0;
        tick(2);

        // Single request on index 1; cycle 0 starts here.
        n_grant = 0; n_reboot = 0;
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        check("t1_grant_c1", 32'(grant), 32'h0);
        check("t1_busy_c1",  32'(busy),  32'h0);
        tick(1);
        check("t1_grant_c2", 32'(grant),      32'h2);
        check("t1_busy_c2",  32'(busy),       32'h1);
        check("t1_addr_c2",  32'(spi_addr),   32'(ADDR1));
        check("t1_rbt_c2",   32'(MBT_REBOOT), 32'h0);
        tick(1);
        check("t1_grant_c3", 32'(grant), 32'h0);
        tick(2);
        check("t1_rbt_c5",   32'(MBT_REBOOT), 32'h0);
        tick(1);
        check("t1_rbt_c6",   32'(MBT_REBOOT), 32'h1);
        tick(1);
        check("t1_rbt_c7",   32'(MBT_REBOOT), 32'h0);
        check("t1_busy_c7",  32'(busy),       32'h1);
        tick(31);
        check("t1_busy_c38", 32'(busy), 32'h1);
        tick(1);
        check("t1_busy_c39", 32'(busy), 32'h0);
        check("t1_nrbt",     32'(n_reboot), 32'h1);
        check("t1_ngrant",   32'(n_grant),  32'h1);
        tick(2);

        // Simultaneous requests on 2 and 0: priority, then back-to-back spacing.
        n_grant = 0; n_reboot = 0;
        req = 4'b0101;
        tick(1);
        req = 4'b0000;
        tick(1);
        check("t2_grant_c2",  32'(grant),    32'h1);
        check("t2_addr_c2",   32'(spi_addr), 32'(ADDR0));
        tick(37);
        check("t2_busy_c39",  32'(busy),     32'h0);
        check("t2_grant_c39", 32'(grant),    32'h0);
        check("t2_addr_c39",  32'(spi_addr), 32'(ADDR0));
        tick(1);
        check("t2_grant_c40", 32'(grant),    32'h4);
        check("t2_addr_c40",  32'(spi_addr), 32'(ADDR2));
        check("t2_busy_c40",  32'(busy),     32'h1);
        tick(40);
        check("t2_busy_end",  32'(busy),     32'h0);
        check("t2_ngrant",    32'(n_grant),  32'h2);
        check("t2_nrbt",      32'(n_reboot), 32'h2);

        // Held request counts once.
        n_grant = 0; n_reboot = 0;
        req[3] = 1'b1;
        tick(100);
        req[3] = 1'b0;
        tick(5);
        check("t3_ngrant", 32'(n_grant),  32'h1);
        check("t3_nrbt",   32'(n_reboot), 32'h1);
        check("t3_addr",   32'(spi_addr), 32'(ADDR3));
        check("t3_busy",   32'(busy),     32'h0);

        // Reset during SETTLE discards the sequence and the queue.
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(1);
        check("t4_grant_c2", 32'(grant), 32'h2);
        tick(1);
        MBT_RESET = 1'b1;
        tick(1);
        MBT_RESET = 1'b0;
        check("t4_rbt",   32'(MBT_REBOOT), 32'h0);
        check("t4_busy",  32'(busy),       32'h0);
        check("t4_addr",  32'(spi_addr),   32'h058000);
        check("t4_grant", 32'(grant),      32'h0);
        n_grant = 0; n_reboot = 0;
        tick(60);
        check("t4_ngrant", 32'(n_grant),  32'h0);
        check("t4_nrbt",   32'(n_reboot), 32'h0);
        check("t4_busy_end", 32'(busy),   32'h0);

        // Re-request in the grant cycle is re-queued after HOLD.
        n_grant = 0; n_reboot = 0;
        req[0] = 1'b1;
        tick(1);
        req[0] = 1'b0;
        tick(1);
        check("t5_grant_c2", 32'(grant), 32'h1);
        req[0] = 1'b1;
        tick(1);
        req[0] = 1'b0;
        tick(37);
        check("t5_grant_c40", 32'(grant), 32'h1);
        tick(45);
        check("t5_nrbt",   32'(n_reboot), 32'h2);
        check("t5_ngrant", 32'(n_grant),  32'h2);
        check("t5_busy",   32'(busy),     32'h0);

`ifdef MBT_LOCK_EN
        // Lock holds off arbitration while still capturing the edge.
        n_grant = 0; n_reboot = 0;
        lock   = 1'b1;
        req[1] = 1'b1;
        tick(1);
        req[1] = 1'b0;
        tick(49);
        check("t6_ngrant_locked", 32'(n_grant), 32'h0);
        check("t6_busy_locked",   32'(busy),    32'h0);
        lock = 1'b0;
        check("t6_grant_c50", 32'(grant), 32'h0);
        tick(1);
        check("t6_grant_c51", 32'(grant), 32'h2);
        tick(40);
        check("t6_nrbt", 32'(n_reboot), 32'h1);
        check("t6_busy", 32'(busy),     32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
